// File: rtl/dice_pkg.sv
// Shared types, constants and helpers for the pushbutton dice roller.
package dice_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROLLING  = 2'd1,
        SETTLING = 2'd2,
        SHOW     = 2'd3
    } dice_state_t;

    localparam int unsigned LFSR_W    = 16;
    localparam int unsigned FACE_W    = 3;
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    // One right shift of the Galois LFSR; the mask is folded in when bit 0 falls out.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
    endfunction

    // Fold a raw 3-bit value into 0..n-1 with a single conditional subtract.
    function automatic logic [FACE_W-1:0] face_reduce(input logic [FACE_W-1:0] raw,
                                                      input int unsigned      n);
        if (32'(raw) < n) begin
            return raw;
        end
        return raw - FACE_W'(n);
    endfunction

endpackage

// File: rtl/dice_roller_button_debouncer.sv
// Two-flop synchronizer plus counter-based debouncer for a raw pushbutton.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic level,
    output logic rise
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;

    logic             w_differ;
    logic             w_flip;

    assign w_differ = (r_sync1 != r_level);
    assign w_flip   = w_differ && (r_cnt == CNT_LAST);

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b0;
            r_sync1 <= 1'b0;
        end else begin
            r_sync0 <= btn_raw;
            r_sync1 <= r_sync0;
        end
    end

    // Count consecutive differing samples; flip the level once enough have been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            if (!w_differ || w_flip) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_level <= w_flip ? ~r_level : r_level;
            r_rise  <= w_flip && !r_level;
        end
    end

    assign level = r_level;
    assign rise  = r_rise;

endmodule

// File: rtl/dice_roller.sv
// Pushbutton dice: animates while held, decelerates after release, then shows a face.
module dice_roller
    import dice_pkg::*;
#(
    parameter int unsigned NUM_FACES       = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned ROLL_PERIOD     = 2500000,
    parameter int unsigned SETTLE_STEPS    = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn,
    output logic [FACE_W-1:0] s,
    output logic              rolling,
    output logic              done
);

    localparam int unsigned PER_MAX = ROLL_PERIOD << SETTLE_STEPS;
    localparam int unsigned PER_W   = $clog2(PER_MAX + 1);
    localparam int unsigned K_W     = $clog2(SETTLE_STEPS + 1);

    logic              w_level;
    logic              w_rise;

    logic [LFSR_W-1:0] r_lfsr;
    dice_state_t       r_state;
    logic [PER_W-1:0]  r_cnt;
    logic [K_W-1:0]    r_k;
    logic [FACE_W-1:0] r_s;
    logic              r_rolling;
    logic              r_done;

    dice_state_t       w_state_nxt;
    logic [PER_W-1:0]  w_cnt_nxt;
    logic [K_W-1:0]    w_k_nxt;
    logic [FACE_W-1:0] w_s_nxt;
    logic              w_rolling_nxt;
    logic              w_done_nxt;

    logic [FACE_W-1:0] w_face;
    logic [PER_W-1:0]  w_period;
    logic              w_fire;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_raw (btn),
        .level   (w_level),
        .rise    (w_rise)
    );

    // Candidate face from the low LFSR bits, folded into range.
    assign w_face   = face_reduce(r_lfsr[FACE_W-1:0], NUM_FACES);
    // Step interval doubles with each settle step; k is zero while rolling.
    assign w_period = PER_W'(ROLL_PERIOD) << r_k;
    assign w_fire   = (r_cnt == (w_period - PER_W'(1)));

    // Free-running pseudo-random source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else begin
            r_lfsr <= lfsr_step(r_lfsr);
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_k       <= '0;
            r_s       <= '0;
            r_rolling <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_k       <= w_k_nxt;
            r_s       <= w_s_nxt;
            r_rolling <= w_rolling_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Next-state and step logic.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_k_nxt     = r_k;
        w_s_nxt     = r_s;
        w_done_nxt  = 1'b0;

        case (r_state)
            IDLE, SHOW: begin
                if (w_rise) begin
                    w_state_nxt = ROLLING;
                    w_s_nxt     = w_face;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end
            end

            ROLLING: begin
                if (w_fire) begin
                    w_s_nxt   = w_face;
                    w_cnt_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + PER_W'(1);
                end
                // A coincident step has already committed its face above.
                if (!w_level) begin
                    w_state_nxt = SETTLING;
                    w_k_nxt     = K_W'(1);
                    w_cnt_nxt   = '0;
                end
            end

            SETTLING: begin
                if (w_level) begin
                    w_state_nxt = ROLLING;
                    w_s_nxt     = w_face;
                    w_cnt_nxt   = '0;
                    w_k_nxt     = '0;
                end else if (w_fire) begin
                    w_s_nxt   = w_face;
                    w_cnt_nxt = '0;
                    if (r_k == K_W'(SETTLE_STEPS)) begin
                        w_state_nxt = SHOW;
                        w_k_nxt     = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_k_nxt = r_k + K_W'(1);
                    end
                end else begin
                    w_cnt_nxt = r_cnt + PER_W'(1);
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_rolling_nxt = (w_state_nxt == ROLLING) || (w_state_nxt == SETTLING);
    end

    assign s       = r_s;
    assign rolling = r_rolling;
    assign done    = r_done;

endmodule

// File: tb/tb_dice_roller.sv
// Self-checking bench for dice_roller: six- and eight-face instances on shared stimulus.
module tb_dice_roller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn;
    logic [2:0] s6, s8;
    logic       ro6, ro8, d6, d8;

    always #5 clk = ~clk;

    dice_roller #(
        .NUM_FACES       (6),
        .DEBOUNCE_CYCLES (4),
        .ROLL_PERIOD     (8),
        .SETTLE_STEPS    (2),
        .LFSR_SEED       (16'hACE1)
    ) u_dut6 (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .s       (s6),
        .rolling (ro6),
        .done    (d6)
    );

    dice_roller #(
        .NUM_FACES       (8),
        .DEBOUNCE_CYCLES (4),
        .ROLL_PERIOD     (8),
        .SETTLE_STEPS    (2),
        .LFSR_SEED       (16'hACE1)
    ) u_dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn     (btn),
        .s       (s8),
        .rolling (ro8),
        .done    (d8)
    );

    typedef struct {
        int press_len;   // btn high on edges 1..press_len
        int repress_at;  // btn high again from this edge on (0 = never)
        int run_edges;   // edges observed before the closing reset
    } scen_t;

    typedef struct {
        int scen;
        int cyc;
        bit done;
    } evrow_t;

    typedef struct {
        int         cyc;
        logic [2:0] s;
        logic       rolling;
        logic       done;
    } ev_t;

    localparam int NSCEN = 6;
    localparam int NEV   = 22;

    scen_t  scen_tab [NSCEN];
    evrow_t ev_tab   [NEV];
    ev_t    q6[$];
    ev_t    q8[$];

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc;
    int         dbl_done    = 0;
    logic [7:0] seen8       = 8'h00;
    logic [7:0] exp8        = 8'h00;
    logic [2:0] prev_s  [2];
    logic       prev_ro [2];
    logic       prev_d  [2];

    // Golden LFSR: value after n shifts from the seed.
    function automatic logic [15:0] lfsr_at(input int n);
        logic [15:0] x;
        x = 16'hACE1;
        for (int i = 0; i < n; i++) begin
            if (x[0]) x = (x >> 1) ^ 16'hB400;
            else      x = x >> 1;
        end
        return x;
    endfunction

    function automatic logic [2:0] face_of(input logic [15:0] l, input int nf);
        logic [2:0] v;
        v = l[2:0];
        if (int'(v) < nf) return v;
        return 3'(int'(v) - nf);
    endfunction

    function automatic bit btn_at(input int sc, input int n);
        return ((n >= 1) && (n <= scen_tab[sc].press_len)) ||
               ((scen_tab[sc].repress_at > 0) && (n >= scen_tab[sc].repress_at));
    endfunction

    task automatic chk(input string name, input int id, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d cyc=%0d got %0d expected %0d", name, id, cyc, act, exp);
        end
    endtask

    // Compare one DUT against its scoreboard for the edge just completed.
    task automatic mon(input int id, input logic [2:0] s_v, input logic ro_v, input logic d_v);
        ev_t e;
        bit  have;
        have = 1'b0;
        if (id == 0) begin
            if (q6.size() > 0 && q6[0].cyc == cyc) begin
                e = q6.pop_front();
                have = 1'b1;
            end
        end else begin
            if (q8.size() > 0 && q8[0].cyc == cyc) begin
                e = q8.pop_front();
                have = 1'b1;
            end
        end
        if (have) begin
            chk("step_face", id, int'(s_v), int'(e.s));
            chk("step_rolling", id, int'(ro_v), int'(e.rolling));
            chk("step_done", id, int'(d_v), int'(e.done));
            if (id == 1) begin
                seen8 = seen8 | (8'h01 << s_v);
                exp8  = exp8  | (8'h01 << e.s);
            end
        end else begin
            chk("hold_face", id, int'(s_v), int'(prev_s[id]));
            chk("hold_rolling", id, int'(ro_v), int'(prev_ro[id]));
            chk("idle_done", id, int'(d_v), 0);
        end
        if (d_v && prev_d[id]) dbl_done++;
        prev_s[id]  = s_v;
        prev_ro[id] = ro_v;
        prev_d[id]  = d_v;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Sample away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_s", 0, int'(s6), 0);
            chk("reset_rolling", 0, int'(ro6), 0);
            chk("reset_done", 0, int'(d6), 0);
            chk("reset_s", 1, int'(s8), 0);
            chk("reset_rolling", 1, int'(ro8), 0);
            chk("reset_done", 1, int'(d8), 0);
            for (int i = 0; i < 2; i++) begin
                prev_s[i]  = 3'd0;
                prev_ro[i] = 1'b0;
                prev_d[i]  = 1'b0;
            end
        end else begin
            mon(0, s6, ro6, d6);
            mon(1, s8, ro8, d8);
        end
    end

    initial begin
        ev_t e;

        // Scenarios: reset/first roll, glitch, full roll, re-press, mid-roll reset, restart.
        scen_tab[0] = '{press_len: 100, repress_at: 0,  run_edges: 12};
        scen_tab[1] = '{press_len: 3,   repress_at: 0,  run_edges: 50};
        scen_tab[2] = '{press_len: 40,  repress_at: 0,  run_edges: 100};
        scen_tab[3] = '{press_len: 40,  repress_at: 70, run_edges: 98};
        scen_tab[4] = '{press_len: 100, repress_at: 0,  run_edges: 20};
        scen_tab[5] = '{press_len: 100, repress_at: 0,  run_edges: 12};

        // Expected face-commit edges counted from reset release.
        ev_tab[0]  = '{scen: 0, cyc: 7,  done: 1'b0};
        ev_tab[1]  = '{scen: 2, cyc: 7,  done: 1'b0};
        ev_tab[2]  = '{scen: 2, cyc: 15, done: 1'b0};
        ev_tab[3]  = '{scen: 2, cyc: 23, done: 1'b0};
        ev_tab[4]  = '{scen: 2, cyc: 31, done: 1'b0};
        ev_tab[5]  = '{scen: 2, cyc: 39, done: 1'b0};
        ev_tab[6]  = '{scen: 2, cyc: 47, done: 1'b0};
        ev_tab[7]  = '{scen: 2, cyc: 63, done: 1'b0};
        ev_tab[8]  = '{scen: 2, cyc: 95, done: 1'b1};
        ev_tab[9]  = '{scen: 3, cyc: 7,  done: 1'b0};
        ev_tab[10] = '{scen: 3, cyc: 15, done: 1'b0};
        ev_tab[11] = '{scen: 3, cyc: 23, done: 1'b0};
        ev_tab[12] = '{scen: 3, cyc: 31, done: 1'b0};
        ev_tab[13] = '{scen: 3, cyc: 39, done: 1'b0};
        ev_tab[14] = '{scen: 3, cyc: 47, done: 1'b0};
        ev_tab[15] = '{scen: 3, cyc: 63, done: 1'b0};
        ev_tab[16] = '{scen: 3, cyc: 76, done: 1'b0};
        ev_tab[17] = '{scen: 3, cyc: 84, done: 1'b0};
        ev_tab[18] = '{scen: 3, cyc: 92, done: 1'b0};
        ev_tab[19] = '{scen: 4, cyc: 7,  done: 1'b0};
        ev_tab[20] = '{scen: 4, cyc: 15, done: 1'b0};
        ev_tab[21] = '{scen: 5, cyc: 7,  done: 1'b0};

        btn   = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        for (int sc = 0; sc < NSCEN; sc++) begin
            btn = (scen_tab[sc].press_len > 0);
            repeat (3) @(negedge clk);

            for (int i = 0; i < NEV; i++) begin
                if (ev_tab[i].scen == sc) begin
                    e.cyc     = ev_tab[i].cyc;
                    e.done    = ev_tab[i].done;
                    e.rolling = !ev_tab[i].done;
                    e.s       = face_of(lfsr_at(ev_tab[i].cyc - 1), 6);
                    q6.push_back(e);
                    e.s       = face_of(lfsr_at(ev_tab[i].cyc - 1), 8);
                    q8.push_back(e);
                end
            end

            rst_n = 1'b1;
            for (int n = 1; n <= scen_tab[sc].run_edges; n++) begin
                btn = btn_at(sc, n);
                @(negedge clk);
            end

            chk("events_pending", 0, q6.size(), 0);
            chk("events_pending", 1, q8.size(), 0);
            q6.delete();
            q8.delete();

            // Asynchronous reset between edges must clear outputs at once.
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("async_reset_s", 0, int'(s6), 0);
            chk("async_reset_rolling", 0, int'(ro6), 0);
            chk("async_reset_s", 1, int'(s8), 0);
            chk("async_reset_rolling", 1, int'(ro8), 0);
        end

        repeat (2) @(negedge clk);
        chk("double_done", 0, dbl_done, 0);
        chk("face8_coverage", 1, int'(seen8), int'(exp8));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
